pipelined_cla_addsub: RTL and testbench
=======================================

# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor: the next generation of the team's 16-bit CLA adder. It is generalised to WIDTH bits split across STAGES register-separated segments, with add/add-with-carry/subtract/subtract-with-borrow modes. A valid/ready handshake on both sides gives full backpressure support. It sits between the operand-fetch logic and the ALU result mux, and it is the datapath adder for multi-cycle arithmetic.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4·STAGES.
- STAGES, 2, pipeline depth; must be 1..WIDTH/4. The segment width SEG = WIDTH/STAGES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block accepts the operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- c_in  in  1  carry (ADC) or borrow (SBB) input; ignored for ADD/SUB.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB. For SUB/SBB this is the raw carry, so 1 means no borrow.
- overflow  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0.

## Operation
- Effective B operand: b for ADD/ADC, ~b for SUB/SBB.
- Effective carry-in:
  - ADD: 0.
  - ADC: c_in.
  - SUB: 1.
  - SBB: ~c_in (c_in = 1 means borrow).
- Stage k (0..STAGES-1) adds bits [k·SEG +: SEG] using the registered carry from stage k-1. Stage 0 uses the effective carry-in.
- Upper operand slices travel unchanged through skew registers until their stage is reached.
- Lower result slices travel forward through de-skew registers, so all WIDTH bits of sum emerge together.
- The overflow flag is computed only in the final stage, as carry-into-MSB XOR carry-out-of-MSB.
- The zero flag is computed in the final stage from the assembled sum.
- Each stage has a valid bit. The whole pipeline advances on `advance = ~out_valid | out_ready`, which is a global stall.
- `in_ready = advance`. A transfer occurs when `in_valid & in_ready`.
- When out_valid is high and out_ready is low, all stage registers, including the output registers, hold their values.
- Bubbles are not compressed: the pipeline is a fixed-latency shift register of valid bits.

## Timing
- Latency is exactly STAGES cycles from the accepting edge to out_valid, when there is no stall. STAGES = 1 means the result is registered one cycle after acceptance.
- Throughput is 1 result per cycle while out_ready is held high.
- A stall of N cycles delays every in-flight result by N cycles. No result is dropped or duplicated.
- Reset (asynchronous, rst_n low):
  - All valid bits clear; out_valid = 0.
  - sum = 0, c_out = 0, overflow = 0, zero = 0.
  - in_ready = 1 during reset, because advance = 1.
- Reset asserted mid-operation discards all in-flight operations, with no partial outputs. The first accepted transfer after deassertion produces a result STAGES cycles later.
- in_valid low while advancing injects a bubble, and out_valid drops for one cycle when that bubble reaches the output.
- sum and the flags are don't-care when out_valid = 0, but they must still hold their last value; the bench checks this.
- Simultaneous accept and drain in the same cycle with a full pipeline is legal and keeps throughput at 1 per cycle.

## Structure
- Shared package `alu_pkg`: op encodings OP_ADD, OP_ADC, OP_SUB, OP_SBB, and the op width constant.
- Sub-module `cla_segment`: a combinational SEG-bit CLA with inputs A, B, C_in and outputs S, C_out, and carry-into-MSB. It is built from the existing 4-bit CLA adders and 4-bit lookahead unit, using a generate loop with a second lookahead level when SEG > 16.
- The top level is `pipelined_cla_addsub`, which contains the operand skew registers, result de-skew registers, valid shift chain, stall logic and flag logic.
- Parameter legality is checked with an elaboration-time error on a bad WIDTH/STAGES combination.

## Test plan
All scenarios use WIDTH = 32 and STAGES = 2 unless stated otherwise.
- ADD 0xFFFF_FFFF + 0x0000_0001 -> after 2 cycles: sum = 0, c_out = 1, zero = 1, overflow = 0.
- SUB 0x8000_0000 − 0x0000_0001 -> sum = 0x7FFF_FFFF, overflow = 1, c_out = 1.
- ADC/SBB chaining: ADC 0x0000_FFFF + 0x0000_0001 with c_in = 1 -> sum = 0x0001_0001. SBB 5 − 3 with c_in = 1 -> sum = 1, c_out = 1.
- Carry across the segment boundary: 0x0000_FFFF + 0x0000_0001 (SEG = 16) -> sum = 0x0001_0000. The carry is registered and arrives correctly in stage 1.
- Backpressure:
  - Stimulus: stream 8 random ops back-to-back while holding out_ready low for cycles 3–6.
  - in_ready must be low exactly while out_valid is high and out_ready is low.
  - All 8 results must appear in order and match the reference model; outputs must hold stable during the stall.
- Reset mid-stream: drop rst_n with 2 ops in flight -> out_valid = 0 and sum = 0 immediately, with no stale result after release. Repeat the scenario with STAGES = 1 and STAGES = 4, WIDTH = 16.

Source files
------------

// File: rtl/alu_pkg.sv
// Operation encodings shared by the ALU datapath blocks, plus the helper that
// folds op and c_in into the carry entering bit 0.
package alu_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBB = 2'b11
    } alu_op_e;

    // Subtraction is a + ~b + 1; SBB's c_in means "borrow", so it removes the +1.
    function automatic logic eff_carry(input logic [OP_W-1:0] op, input logic c_in);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_ADC:  c = c_in;
            OP_SUB:  c = 1'b1;
            default: c = ~c_in;
        endcase
        return c;
    endfunction

    function automatic logic is_subtract(input logic [OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational carry-lookahead segment: 4-bit CLA groups, a first lookahead
// level over groups of 4 and a second level over 16-bit blocks.
module cla_lookahead4 (
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       c_i,
    output logic [3:0] c_o,
    output logic       p_o,
    output logic       g_o
);
    assign c_o[0] = c_i;
    assign c_o[1] = g_i[0] | (p_i[0] & c_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);
    assign p_o    = &p_i;
    assign g_o    = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                  | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
endmodule

module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       p_o,
    output logic       g_o,
    output logic       c3_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    cla_lookahead4 u_la (
        .p_i (p),
        .g_i (g),
        .c_i (c_i),
        .c_o (c),
        .p_o (p_o),
        .g_o (g_o)
    );

    assign s_o  = p ^ c;
    assign c3_o = c[3];
endmodule

module cla_segment #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] s_o,
    output logic           c_o,
    output logic           c_msb_o
);
    localparam int N4  = SEG / 4;
    localparam int N16 = (N4 + 3) / 4;
    localparam int N64 = (N16 + 3) / 4;

    logic [N16*4-1:0] gp;
    logic [N16*4-1:0] gg;
    logic [N16*4-1:0] gc;
    logic [N4-1:0]    c3;
    logic [N64*4-1:0] sp;
    logic [N64*4-1:0] sg;
    logic [N64*4-1:0] sc;
    logic [N64-1:0]   bp;
    logic [N64-1:0]   bg;
    logic [N64:0]     bc;
    logic             unused_carries;

    for (genvar i = 0; i < N4; i++) begin : g_grp
        cla4 u_cla4 (
            .a_i  (a_i[4*i +: 4]),
            .b_i  (b_i[4*i +: 4]),
            .c_i  (gc[i]),
            .s_o  (s_o[4*i +: 4]),
            .p_o  (gp[i]),
            .g_o  (gg[i]),
            .c3_o (c3[i])
        );
    end

    // Missing groups/blocks are padded as pure propagate so that partial
    // lookahead units still report the true group generate/propagate.
    for (genvar i = N4; i < N16*4; i++) begin : g_grp_pad
        assign gp[i] = 1'b1;
        assign gg[i] = 1'b0;
    end

    for (genvar j = 0; j < N16; j++) begin : g_lvl1
        cla_lookahead4 u_la1 (
            .p_i (gp[4*j +: 4]),
            .g_i (gg[4*j +: 4]),
            .c_i (sc[j]),
            .c_o (gc[4*j +: 4]),
            .p_o (sp[j]),
            .g_o (sg[j])
        );
    end

    for (genvar j = N16; j < N64*4; j++) begin : g_blk_pad
        assign sp[j] = 1'b1;
        assign sg[j] = 1'b0;
    end

    assign bc[0] = c_i;
    for (genvar k = 0; k < N64; k++) begin : g_lvl2
        cla_lookahead4 u_la2 (
            .p_i (sp[4*k +: 4]),
            .g_i (sg[4*k +: 4]),
            .c_i (bc[k]),
            .c_o (sc[4*k +: 4]),
            .p_o (bp[k]),
            .g_o (bg[k])
        );
        assign bc[k+1] = bg[k] | (bp[k] & bc[k]);
    end

    assign c_o            = bc[N64];
    assign c_msb_o        = c3[N4-1];
    assign unused_carries = ^{gc, sc};
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor: one SEG-bit segment per stage, operand skew
// and result de-skew registers, a global-stall valid chain and final flags.
module pipelined_cla_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG  = WIDTH / ((STAGES < 1) ? 1 : STAGES);
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || WIDTH < 4 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH=%0d must be a multiple of 4*STAGES (STAGES=%0d)",
               WIDTH, STAGES);
    end

    // Handshake: a rank moves forward only on advance; a result leaves when
    // out_valid & out_ready, and operands enter when in_valid & in_ready.
    logic                advance;
    logic [STAGES-1:0]   valid_q, valid_d;
    logic [WIDTH-1:0]    a_q [STAGES];
    logic [WIDTH-1:0]    a_d [STAGES];
    logic [WIDTH-1:0]    b_q [STAGES];
    logic [WIDTH-1:0]    b_d [STAGES];
    logic [WIDTH-1:0]    s_q [STAGES];
    logic [WIDTH-1:0]    s_d [STAGES];
    logic [WIDTH-1:0]    s_prev [STAGES];
    logic [STAGES-1:0]   c_q;
    logic [STAGES-1:0]   seg_ci;
    logic [STAGES-1:0]   seg_c;
    logic [STAGES-1:0]   seg_cm;
    logic [SEG-1:0]      seg_s [STAGES];
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic                unused_ops;

    assign advance  = ~valid_q[LAST] | out_ready;
    assign in_ready = advance;

    // Rank k's inputs: the bus for k = 0, otherwise the registers of rank k-1.
    always_comb begin
        a_d[0]    = a;
        b_d[0]    = is_subtract(op) ? ~b : b;
        seg_ci[0] = eff_carry(op, c_in);
        valid_d[0] = in_valid;
        s_prev[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            seg_ci[k]  = c_q[k-1];
            valid_d[k] = valid_q[k-1];
            s_prev[k]  = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_segment #(.SEG(SEG)) u_seg (
            .a_i     (a_d[k][k*SEG +: SEG]),
            .b_i     (b_d[k][k*SEG +: SEG]),
            .c_i     (seg_ci[k]),
            .s_o     (seg_s[k]),
            .c_o     (seg_c[k]),
            .c_msb_o (seg_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_prev[k];
            s_d[k][k*SEG +: SEG] = seg_s[k];
        end
        ovf_d  = seg_cm[LAST] ^ seg_c[LAST];
        zero_d = (s_d[LAST] == '0);
    end

    // Data registers load only with a valid beat so bubbles leave outputs held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                if (valid_d[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= seg_c[k];
                end
            end
            if (valid_d[LAST]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid  = valid_q[LAST];
    assign sum        = s_q[LAST];
    assign c_out      = c_q[LAST];
    assign overflow   = ovf_q;
    assign zero       = zero_q;
    assign unused_ops = ^{a_q[LAST], b_q[LAST], seg_cm};
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub (32/2 main instance, 16/1 and 16/4
// instances for the reset-latency scenario).
module tb_pipelined_cla_addsub;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        c_in;
    logic        out_ready;

    logic        in_ready, out_valid, c_out, overflow, zero;
    logic [31:0] sum;
    logic        in_ready_1, out_valid_1, c_out_1, overflow_1, zero_1;
    logic [15:0] sum_1;
    logic        in_ready_4, out_valid_4, c_out_4, overflow_4, zero_4;
    logic [15:0] sum_4;

    int n_checks = 0;
    int n_pass   = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .c_in(c_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow), .zero(zero)
    );

    pipelined_cla_addsub #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
        .a(a[15:0]), .b(b[15:0]), .op(op), .c_in(c_in), .out_valid(out_valid_1),
        .out_ready(out_ready), .sum(sum_1), .c_out(c_out_1), .overflow(overflow_1), .zero(zero_1)
    );

    pipelined_cla_addsub #(.WIDTH(16), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
        .a(a[15:0]), .b(b[15:0]), .op(op), .c_in(c_in), .out_valid(out_valid_4),
        .out_ready(out_ready), .sum(sum_4), .c_out(c_out_4), .overflow(overflow_4), .zero(zero_4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference via signed/unsigned integer arithmetic: {c_out, overflow, zero, sum}.
    function automatic logic [34:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb, input logic mci);
        longint ua, ub, sa, sb, ur, sr, cc;
        logic   cy, ov;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        cc = (mop == OP_ADC || mop == OP_SBB) ? longint'(mci) : 0;
        if (mop == OP_ADD || mop == OP_ADC) begin
            ur = ua + ub + cc;
            sr = sa + sb + cc;
            cy = (ur > 64'sh0000_0000_FFFF_FFFF);
        end else begin
            ur = ua - ub - cc;
            sr = sa - sb - cc;
            cy = (ur >= 0);
        end
        ov = (sr > 64'sh0000_0000_7FFF_FFFF) || (sr < -64'sh0000_0000_8000_0000);
        return {cy, ov, (ur[31:0] == 32'h0), ur[31:0]};
    endfunction

    task automatic run_vec(input string tag, input logic [1:0] vop, input logic [31:0] va,
                           input logic [31:0] vb, input logic vci, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = vop; a = va; b = vb; c_in = vci;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c_in = ~vci;
        check({tag, "_early"}, out_valid, 1'b0);
        tick();
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_flags"}, {c_out, overflow, zero}, {ec, eo, ez});
        tick();
        check({tag, "_bubble"}, out_valid, 1'b0);
        check({tag, "_hold"}, {c_out, overflow, zero, sum}, {ec, eo, ez, es});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, recv, cyc;
        logic acc, prev_stall;
        logic [35:0] prev_out;
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [1:0]  vop [8];
        logic        vci [8];
        logic [34:0] e;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; c_in = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", {c_out, overflow, zero, sum}, 35'h0);
        check("rst_in_ready", {in_ready, in_ready_1, in_ready_4}, 3'b111);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_vec("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_vec("sub_ovf",   OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_vec("adc_chain", OP_ADC, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0, 1'b0);
        run_vec("sbb_chain", OP_SBB, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        run_vec("seg_carry", OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        run_vec("add_ign_c", OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_vec("sub_borrow",OP_SUB, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_vec("sbb_zero",  OP_SBB, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_vec("sbb_bor",   OP_SBB, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_vec("add_povf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_vec("adc_wrap",  OP_ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: 8 back-to-back ops, out_ready low during cycles 3..6.
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom; vb[i] = $urandom;
            vop[i] = 2'($urandom_range(0, 3)); vci[i] = 1'($urandom_range(0, 1));
        end
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001; vop[2] = OP_ADD;
        sent = 0; recv = 0; prev_stall = 1'b0; prev_out = '0;
        for (cyc = 0; cyc < 40 && (sent < 8 || exp_q.size() > 0); cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 8) begin
                in_valid = 1'b1; a = va[sent]; b = vb[sent]; op = vop[sent]; c_in = vci[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("bp_in_ready_c%0d", cyc), in_ready, !(out_valid && !out_ready));
            if (prev_stall)
                check($sformatf("bp_hold_c%0d", cyc), {out_valid, c_out, overflow, zero, sum}, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("bp_extra_c%0d", cyc), 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("bp_res%0d", recv), {c_out, overflow, zero, sum}, e);
                end
                recv++;
            end
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(model(vop[sent], va[sent], vb[sent], vci[sent]));
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, c_out, overflow, zero, sum};
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", recv, 8);
        check("bp_sent", sent, 8);

        // Reset with operations in flight, then first-result latency per depth.
        tick();
        tick();
        op = OP_ADD; c_in = 1'b0;
        in_valid = 1'b1; a = 32'h0000_0001; b = 32'h0000_0002;
        tick();
        a = 32'h0000_0003; b = 32'h0000_0004;
        tick();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rrst_valid", {out_valid, out_valid_1, out_valid_4}, 3'b000);
        check("rrst_sum32", sum, 32'h0);
        check("rrst_sum16", {sum_1, sum_4}, 32'h0);
        check("rrst_flags", {c_out, overflow, zero, c_out_1, overflow_1, zero_1,
                             c_out_4, overflow_4, zero_4}, 9'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rrst_stale%0d", k), {out_valid, out_valid_1, out_valid_4}, 3'b000);
        end
        check("rrst_sum_idle", {sum, sum_1, sum_4}, 64'h0);
        in_valid = 1'b1; a = 32'h0000_1234; b = 32'h0000_0101;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
            check($sformatf("rlat_valid%0d", k), {out_valid_1, out_valid, out_valid_4},
                  {k == 1, k == 2, k == 4});
            if (k == 1) check("rlat_s1", {c_out_1, overflow_1, zero_1, sum_1}, {3'b000, 16'h1335});
            if (k == 2) check("rlat_s2", {c_out, overflow, zero, sum}, {3'b000, 32'h0000_1335});
            if (k == 4) check("rlat_s4", {c_out_4, overflow_4, zero_4, sum_4}, {3'b000, 16'h1335});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
